// File: rtl/branch_predictor_if.sv
// Fetch-side lookup and MEM-side resolve bundle between the pipeline and the branch predictor.
interface branch_predictor_if #(
  parameter int unsigned XLEN     = 32,
  parameter int unsigned GHR_BITS = 6,
  parameter int unsigned PERF_W   = 32
);
  logic [XLEN-1:0]     pred_pc;
  logic                pred_taken;
  logic [XLEN-1:0]     pred_target;
  logic [GHR_BITS-1:0] pred_ghr;
  logic                hold;
  logic                upd_valid;
  logic [XLEN-1:0]     upd_pc;
  logic                upd_is_cond;
  logic                upd_taken;
  logic [XLEN-1:0]     upd_target;
  logic [GHR_BITS-1:0] upd_ghr;
  logic                upd_pred_taken;
  logic [XLEN-1:0]     upd_pred_target;
  logic                mispredict;
  logic [PERF_W-1:0]   branch_total;
  logic [PERF_W-1:0]   mispredict_total;

  modport master (
    output pred_pc, hold, upd_valid, upd_pc, upd_is_cond, upd_taken, upd_target,
           upd_ghr, upd_pred_taken, upd_pred_target,
    input  pred_taken, pred_target, pred_ghr, mispredict, branch_total, mispredict_total
  );

  modport slave (
    input  pred_pc, hold, upd_valid, upd_pc, upd_is_cond, upd_taken, upd_target,
           upd_ghr, upd_pred_taken, upd_pred_target,
    output pred_taken, pred_target, pred_ghr, mispredict, branch_total, mispredict_total
  );
endinterface

// File: rtl/branch_predictor.sv
// Dynamic branch predictor: saturating-counter BHT (bimodal or gshare), direct-mapped BTB,
// non-speculative global history and branch/mispredict counters.
module branch_predictor #(
  parameter int unsigned XLEN      = 32,
  parameter int unsigned BHT_IDX_W = 6,
  parameter int unsigned CNT_W     = 2,
  parameter int unsigned GHR_W     = 6,
  parameter int unsigned BTB_IDX_W = 4,
  parameter int unsigned TAG_W     = 8,
  parameter int unsigned PERF_W    = 32
) (
  input  logic              clk,
  input  logic              rst,
  branch_predictor_if.slave bp
);
  localparam int unsigned GW    = (GHR_W > 0) ? GHR_W : 1;
  localparam int unsigned BHT_N = 1 << BHT_IDX_W;
  localparam int unsigned BTB_N = 1 << BTB_IDX_W;
  localparam logic [CNT_W-1:0] CNT_INIT = CNT_W'((1 << (CNT_W - 1)) - 1);
  localparam logic [CNT_W-1:0] CNT_MAX  = '1;

  logic [CNT_W-1:0]  bht        [BHT_N];
  logic              btb_valid  [BTB_N];
  logic [TAG_W-1:0]  btb_tag    [BTB_N];
  logic [XLEN-1:0]   btb_target [BTB_N];
  logic              btb_jump   [BTB_N];
  logic [GW-1:0]     ghr;
  logic [PERF_W-1:0] branch_total;
  logic [PERF_W-1:0] mispredict_total;

  logic [BHT_IDX_W-1:0] l_bht;
  logic [BHT_IDX_W-1:0] u_bht;
  logic [BTB_IDX_W-1:0] l_btb;
  logic [BTB_IDX_W-1:0] u_btb;
  logic                 l_hit;
  logic                 l_taken;
  logic [CNT_W-1:0]     u_cnt;
  logic                 mispredict;
  logic                 do_upd;
  logic                 unused_bits;

  // gshare folds the history into the low index bits; bimodal uses the PC alone
  function automatic logic [BHT_IDX_W-1:0] bht_index(input logic [XLEN-1:0] pc,
                                                      input logic [GW-1:0]   g);
    if (GHR_W > 0) return pc[BHT_IDX_W+1:2] ^ BHT_IDX_W'(g);
    else           return pc[BHT_IDX_W+1:2];
  endfunction

  always_comb begin
    l_bht   = bht_index(bp.pred_pc, ghr);
    l_btb   = bp.pred_pc[BTB_IDX_W+1:2];
    l_hit   = btb_valid[l_btb] && (btb_tag[l_btb] == bp.pred_pc[BTB_IDX_W+2 +: TAG_W]);
    l_taken = l_hit && (btb_jump[l_btb] || bht[l_bht][CNT_W-1]);
    u_bht   = bht_index(bp.upd_pc, bp.upd_ghr);
    u_btb   = bp.upd_pc[BTB_IDX_W+1:2];
    u_cnt   = bht[u_bht];
  end

  assign mispredict = bp.upd_valid &&
                      ((bp.upd_taken != bp.upd_pred_taken) ||
                       (bp.upd_taken && (bp.upd_target != bp.upd_pred_target)));
  assign do_upd     = bp.upd_valid && !bp.hold;

  assign bp.pred_taken       = l_taken;
  assign bp.pred_target      = l_taken ? btb_target[l_btb] : bp.pred_pc + XLEN'(4);
  assign bp.pred_ghr         = ghr;
  assign bp.mispredict       = mispredict;
  assign bp.branch_total     = branch_total;
  assign bp.mispredict_total = mispredict_total;

  assign unused_bits = ^bp.upd_pc;

  // Reset-visible state: counters, valids, history, performance counters
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int unsigned i = 0; i < BHT_N; i++) bht[BHT_IDX_W'(i)] <= CNT_INIT;
      for (int unsigned i = 0; i < BTB_N; i++) btb_valid[BTB_IDX_W'(i)] <= 1'b0;
      ghr              <= '0;
      branch_total     <= '0;
      mispredict_total <= '0;
    end else if (do_upd) begin
      if (bp.upd_is_cond) begin
        if (bp.upd_taken && (u_cnt != CNT_MAX))       bht[u_bht] <= u_cnt + CNT_W'(1);
        else if (!bp.upd_taken && (u_cnt != '0))      bht[u_bht] <= u_cnt - CNT_W'(1);
        if (GHR_W > 0) ghr <= GW'({ghr, bp.upd_taken});
      end
      if (bp.upd_taken) btb_valid[u_btb] <= 1'b1;
      branch_total <= branch_total + PERF_W'(1);
      if (mispredict) mispredict_total <= mispredict_total + PERF_W'(1);
    end
  end

  // BTB payload is qualified by the valid bit, so it carries no reset
  always_ff @(posedge clk) begin
    if (do_upd && bp.upd_taken) begin
      btb_tag[u_btb]    <= bp.upd_pc[BTB_IDX_W+2 +: TAG_W];
      btb_target[u_btb] <= bp.upd_target;
      btb_jump[u_btb]   <= !bp.upd_is_cond;
    end
  end
endmodule

// File: tb/tb_branch_predictor.sv
// Bench for branch_predictor: a bimodal and a gshare instance share stimulus and are
// checked each cycle against an array-based model of the prediction rules.
module tb_branch_predictor;
  logic clk = 1'b0;
  logic rst;
  int   n_chk  = 0;
  int   n_fail = 0;

  logic [31:0] s_pc, s_upc, s_utgt, s_uptgt;
  logic        s_hold, s_uv, s_ucond, s_utaken, s_uptaken;
  logic [3:0]  s_ughr_gs;
  logic        s_ughr_bi;

  branch_predictor_if #(.XLEN(32), .GHR_BITS(1), .PERF_W(32)) bif ();
  branch_predictor_if #(.XLEN(32), .GHR_BITS(4), .PERF_W(32)) gif ();

  assign bif.pred_pc = s_pc;            assign gif.pred_pc = s_pc;
  assign bif.hold = s_hold;             assign gif.hold = s_hold;
  assign bif.upd_valid = s_uv;          assign gif.upd_valid = s_uv;
  assign bif.upd_pc = s_upc;            assign gif.upd_pc = s_upc;
  assign bif.upd_is_cond = s_ucond;     assign gif.upd_is_cond = s_ucond;
  assign bif.upd_taken = s_utaken;      assign gif.upd_taken = s_utaken;
  assign bif.upd_target = s_utgt;       assign gif.upd_target = s_utgt;
  assign bif.upd_pred_taken = s_uptaken; assign gif.upd_pred_taken = s_uptaken;
  assign bif.upd_pred_target = s_uptgt; assign gif.upd_pred_target = s_uptgt;
  assign bif.upd_ghr = s_ughr_bi;       assign gif.upd_ghr = s_ughr_gs;

  branch_predictor #(.GHR_W(0)) dut_bi (.clk(clk), .rst(rst), .bp(bif));
  branch_predictor #(.GHR_W(4)) dut_gs (.clk(clk), .rst(rst), .bp(gif));

  always #5 clk = ~clk;

  // Reference model, index 0 = bimodal, 1 = gshare with 4-bit history
  int          cnt  [2][64];
  bit          bv   [2][16];
  int          btag [2][16];
  logic [31:0] btgt [2][16];
  bit          bj   [2][16];
  int          ghr  [2];
  logic [31:0] btot [2];
  logic [31:0] mtot [2];

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic void model_reset();
    for (int m = 0; m < 2; m++) begin
      for (int i = 0; i < 64; i++) cnt[m][i] = 1;
      for (int i = 0; i < 16; i++) bv[m][i] = 1'b0;
      ghr[m] = 0; btot[m] = 0; mtot[m] = 0;
    end
  endfunction

  function automatic int bht_idx(input int m, input logic [31:0] pc, input int g);
    int i = int'((pc >> 2) % 64);
    if (m == 1) i = i ^ g;
    return i;
  endfunction

  function automatic bit m_taken(input int m, input logic [31:0] pc);
    int b = int'((pc >> 2) % 16);
    int t = int'((pc >> 6) % 256);
    return bv[m][b] && (btag[m][b] == t) && (bj[m][b] || (cnt[m][bht_idx(m, pc, ghr[m])] >= 2));
  endfunction

  function automatic logic [31:0] m_target(input int m, input logic [31:0] pc);
    return m_taken(m, pc) ? btgt[m][int'((pc >> 2) % 16)] : pc + 32'd4;
  endfunction

  function automatic bit m_misp();
    return s_uv && ((s_utaken != s_uptaken) || (s_utaken && (s_utgt != s_uptgt)));
  endfunction

  function automatic void model_update();
    bit mp = m_misp();
    for (int m = 0; m < 2; m++) begin
      if (s_uv && !s_hold) begin
        if (s_ucond) begin
          int i = bht_idx(m, s_upc, int'(s_ughr_gs));
          cnt[m][i] = s_utaken ? ((cnt[m][i] < 3) ? cnt[m][i] + 1 : 3)
                               : ((cnt[m][i] > 0) ? cnt[m][i] - 1 : 0);
          if (m == 1) ghr[m] = ((ghr[m] << 1) | int'(s_utaken)) % 16;
        end
        if (s_utaken) begin
          int b = int'((s_upc >> 2) % 16);
          bv[m][b] = 1'b1; btag[m][b] = int'((s_upc >> 6) % 256);
          btgt[m][b] = s_utgt; bj[m][b] = !s_ucond;
        end
        btot[m] = btot[m] + 1;
        if (mp) mtot[m] = mtot[m] + 1;
      end
    end
  endfunction

  task automatic compare_all();
    check("bi_taken",  64'(bif.pred_taken),       64'(m_taken(0, s_pc)));
    check("bi_target", 64'(bif.pred_target),      64'(m_target(0, s_pc)));
    check("bi_ghr",    64'(bif.pred_ghr),         64'(0));
    check("bi_misp",   64'(bif.mispredict),       64'(m_misp()));
    check("bi_btot",   64'(bif.branch_total),     64'(btot[0]));
    check("bi_mtot",   64'(bif.mispredict_total), 64'(mtot[0]));
    check("gs_taken",  64'(gif.pred_taken),       64'(m_taken(1, s_pc)));
    check("gs_target", 64'(gif.pred_target),      64'(m_target(1, s_pc)));
    check("gs_ghr",    64'(gif.pred_ghr),         64'(ghr[1]));
    check("gs_misp",   64'(gif.mispredict),       64'(m_misp()));
    check("gs_btot",   64'(gif.branch_total),     64'(btot[1]));
    check("gs_mtot",   64'(gif.mispredict_total), 64'(mtot[1]));
  endtask

  task automatic step();
    #1 compare_all();
    @(posedge clk);
    model_update();
    @(negedge clk);
  endtask

  // pred_pc follows the resolving PC; upd_pred_* come from model pm's IF-time prediction
  task automatic drive(input int pm, input logic [31:0] pc, input logic v, input logic cond,
                       input logic taken, input logic [31:0] tgt, input logic hold);
    s_pc = pc; s_upc = pc; s_uv = v; s_ucond = cond; s_utaken = taken;
    s_utgt = tgt; s_hold = hold; s_ughr_gs = 4'(ghr[1]); s_ughr_bi = 1'b0;
    s_uptaken = m_taken(pm, pc); s_uptgt = m_target(pm, pc);
  endtask

  initial begin
    int late;
    rst = 1'b0;
    model_reset();
    drive(0, 32'h100, 1'b0, 1'b0, 1'b0, 32'h0, 1'b0);
    @(negedge clk);
    #1;
    check("rst_taken",  64'(bif.pred_taken), 64'(0));
    check("rst_target", 64'(bif.pred_target), 64'h104);
    check("rst_btot",   64'(bif.branch_total), 64'(0));
    check("rst_mtot",   64'(gif.mispredict_total), 64'(0));
    @(negedge clk);
    rst = 1'b1;

    drive(0, 32'h200, 1'b1, 1'b1, 1'b1, 32'h180, 1'b0);
    #1 check("first_misp", 64'(bif.mispredict), 64'(1));
    step();
    drive(0, 32'h200, 1'b0, 1'b0, 1'b0, 32'h0, 1'b0);
    #1 check("hit_taken", 64'(bif.pred_taken), 64'(1));
    check("hit_target", 64'(bif.pred_target), 64'h180);
    drive(0, 32'h200, 1'b1, 1'b1, 1'b1, 32'h180, 1'b0);
    #1 check("second_misp", 64'(bif.mispredict), 64'(0));
    step();
    drive(0, 32'h200, 1'b0, 1'b0, 1'b0, 32'h0, 1'b0);
    #1 check("two_btot", 64'(bif.branch_total), 64'(2));
    check("two_mtot", 64'(bif.mispredict_total), 64'(1));
    step();

    repeat (5) begin drive(0, 32'h200, 1'b1, 1'b1, 1'b1, 32'h180, 1'b0); step(); end
    drive(0, 32'h200, 1'b1, 1'b1, 1'b0, 32'h180, 1'b0); step();
    drive(0, 32'h200, 1'b0, 1'b0, 1'b0, 32'h0, 1'b0);
    #1 check("sat_nt1_taken", 64'(bif.pred_taken), 64'(1));
    drive(0, 32'h200, 1'b1, 1'b1, 1'b0, 32'h180, 1'b0); step();
    drive(0, 32'h200, 1'b0, 1'b0, 1'b0, 32'h0, 1'b0);
    #1 check("sat_nt2_taken", 64'(bif.pred_taken), 64'(0));
    check("sat_nt2_target", 64'(bif.pred_target), 64'h204);
    step();

    drive(0, 32'h300, 1'b1, 1'b0, 1'b1, 32'h400, 1'b0); step();
    drive(0, 32'h300, 1'b0, 1'b0, 1'b0, 32'h0, 1'b0);
    #1 check("jal_taken", 64'(gif.pred_taken), 64'(1));
    check("jal_target", 64'(bif.pred_target), 64'h400);
    step();

    drive(0, 32'h600, 1'b1, 1'b1, 1'b1, 32'h640, 1'b1);
    repeat (3) begin #1 check("hold_misp", 64'(bif.mispredict), 64'(1)); step(); end
    s_hold = 1'b0;
    #1 check("hold_btot", 64'(bif.branch_total), 64'(10));
    check("hold_taken", 64'(bif.pred_taken), 64'(0));
    step();
    drive(0, 32'h600, 1'b0, 1'b0, 1'b0, 32'h0, 1'b0);
    #1 check("unhold_taken", 64'(bif.pred_taken), 64'(1));
    step();

    late = 0;
    for (int i = 0; i < 16; i++) begin
      drive(1, 32'h500, 1'b1, 1'b1, (i % 2) == 0, 32'h580, 1'b0);
      #1 if (i >= 8) late += int'(gif.mispredict);
      step();
    end
    check("gs_late_misp", 64'(late), 64'(0));

    drive(1, 32'h500, 1'b1, 1'b1, 1'b1, 32'h580, 1'b0);
    #1 check("gs_pre_rst_taken", 64'(gif.pred_taken), 64'(1));
    rst = 1'b0;
    #1 model_reset();
    check("async_rst_taken", 64'(gif.pred_taken), 64'(0));
    check("async_rst_btot",  64'(gif.branch_total), 64'(0));
    check("async_rst_mtot",  64'(bif.mispredict_total), 64'(0));
    compare_all();
    s_uv = 1'b0;
    @(negedge clk);
    rst = 1'b1;

    repeat (1500) begin
      logic [31:0] pc;
      logic        cond;
      pc   = 32'h1000 + 32'($urandom_range(0, 3) << 6) + 32'(4 * $urandom_range(0, 15));
      cond = ($urandom_range(0, 3) != 0);
      drive($urandom_range(0, 1), pc, ($urandom_range(0, 4) != 0), cond,
            cond ? 1'($urandom) : 1'b1, 32'h2000 + 32'(4 * $urandom_range(0, 7)),
            ($urandom_range(0, 9) == 0));
      if ($urandom_range(0, 3) == 0)
        s_pc = 32'h1000 + 32'($urandom_range(0, 3) << 6) + 32'(4 * $urandom_range(0, 15));
      if ($urandom_range(0, 49) == 0) s_pc = 32'hFFFF_FFFC;
      if ($urandom_range(0, 4) == 0) begin
        s_uptaken = 1'($urandom);
        s_uptgt   = 32'h2000 + 32'(4 * $urandom_range(0, 7));
      end
      if ($urandom_range(0, 9) == 0) s_ughr_gs = 4'($urandom);
      s_ughr_bi = 1'($urandom);
      step();
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule

// File: doc/branch_predictor.md
Name: branch_predictor

Overview:
- Parametrised dynamic branch predictor for the 5-stage pipeline.
- Replaces the static predict-not-taken policy, under which every taken branch, jal or jalr resolved in MEM flushes IF/ID/EX.
- IF queries it each cycle for a predicted next PC. MEM reports resolved control-flow instructions back to it.
- Holds a BHT of saturating counters (bimodal or gshare indexing), a direct-mapped BTB, a global history register, and branch/mispredict performance counters.

Parameters:
- XLEN, 32, address/data width.
- BHT_IDX_W, 6, log2 of BHT entries (64).
- CNT_W, 2, saturating counter width, 2..4.
- GHR_W, 6, global history length. 0 selects bimodal mode; must be <= BHT_IDX_W.
- BTB_IDX_W, 4, log2 of BTB entries (16).
- TAG_W, 8, BTB tag width, taken from pc[BTB_IDX_W+2 +: TAG_W].
- PERF_W, 32, performance counter width.

Ports:
- clk  in  1  clock.
- rst  in  1  asynchronous, active-low reset.
- pred_pc  in  XLEN  IF-stage PC to predict.
- pred_taken  out  1  prediction: redirect.
- pred_target  out  XLEN  predicted next PC.
- pred_ghr  out  max(GHR_W,1)  history snapshot used for this lookup; carried down the pipe.
- hold  in  1  pipeline pause/stall; blocks all state updates.
- upd_valid  in  1  MEM stage holds a resolved br/jal/jalr.
- upd_pc  in  XLEN  PC of the resolved instruction.
- upd_is_cond  in  1  1 = conditional branch, 0 = jal/jalr.
- upd_taken  in  1  actual outcome (always 1 for jumps).
- upd_target  in  XLEN  actual target.
- upd_ghr  in  max(GHR_W,1)  pred_ghr carried with the instruction.
- upd_pred_taken  in  1  prediction made in IF for this instruction.
- upd_pred_target  in  XLEN  predicted target made in IF.
- mispredict  out  1  flush request for IF/ID/EX.
- branch_total  out  PERF_W  resolved control-flow count.
- mispredict_total  out  PERF_W  mispredict count.

Behaviour:
- Lookup is combinational, zero-latency read of the registered arrays.
- BHT index = pc[BHT_IDX_W+1:2] XOR {zeros, ghr} when GHR_W>0; pc bits only when GHR_W=0.
- BTB index = pc[BTB_IDX_W+1:2]. Hit = valid AND tag match.
- Each BTB entry holds valid, tag, target and is_jump.
- pred_taken = hit AND (is_jump OR counter MSB).
- pred_target = pred_taken ? btb target : pred_pc+4, with modulo-2^XLEN wrap.
- pred_ghr = current GHR.
- mispredict (combinational) = upd_valid AND ((upd_taken != upd_pred_taken) OR (upd_taken AND upd_target != upd_pred_target)).
- Updates occur at posedge only when upd_valid=1 and hold=0:
  - Counter: if upd_is_cond, the BHT entry indexed by upd_pc XOR upd_ghr increments (if taken) or decrements (if not), saturating at 0 and 2^CNT_W-1. Jumps leave the BHT untouched.
  - BTB: if upd_taken, write {valid=1, tag, upd_target, is_jump=~upd_is_cond}, overwriting any occupant. Not-taken never allocates or invalidates.
  - GHR: non-speculative. If upd_is_cond, GHR <= {GHR[GHR_W-2:0], upd_taken}; jumps do not shift.
  - Perf: branch_total += 1; mispredict_total += 1 if mispredict. Both wrap at 2^PERF_W.
- hold=1 with upd_valid=1: no state changes. mispredict output is still driven, and the datapath ignores it while paused.
- Same-cycle lookup and update to the same entry: lookup returns the pre-update value; the new value is visible next cycle.
- Reset (rst=0, asynchronous, effective immediately, including mid-operation):
  - All counters to weakly-not-taken, 2^(CNT_W-1)-1.
  - BTB valids to 0.
  - GHR to 0.
  - Perf counters to 0.
  - Consequently pred_taken=0, pred_target=pred_pc+4, pred_ghr=0, branch_total=0, mispredict_total=0.
  - mispredict stays combinational from the upd_* inputs.
- Deassertion is synchronous to the next posedge; the first update may occur on the first posedge with rst=1.

Test Plan:
- Reset then pred_pc=0x100 -> pred_taken=0, pred_target=0x104, both perf counters 0.
- Cond branch at 0x200, target 0x180, resolved taken twice (GHR_W=0) -> cycle after 1st: BTB hit, counter=2, pred_taken=1, pred_target=0x180; mispredict=1 on 1st resolve, 0 on 2nd; branch_total=2, mispredict_total=1.
- Counter saturation: 5 taken resolves, then 1 not-taken -> still predicts taken (counter 3->2); 2nd not-taken -> predicts not-taken, pred_target=0x204.
- jal at 0x300 to 0x400 resolved once -> subsequent lookup pred_taken=1, target 0x400; BHT entry unchanged; GHR unchanged.
- hold=1 with upd_valid=1 for 3 cycles -> no BTB, BHT, GHR or perf change; mispredict still asserted if outcome differs; update applies on the first cycle with hold=0.
- gshare (GHR_W=4): alternating T/N branch at 0x500 for 16 resolves -> mispredict_total stops incrementing after warm-up, with 0 mispredicts in the last 8. Assert rst=0 mid-sequence -> pred_taken=0 and perf counters 0 immediately, without waiting for a clock edge.
